// File: rtl/nx_distributor.sv
// nx_distributor: packet router from one inbound stream to two outbound streams.
// The header beat's MSB selects port A (0) or B (1). The route is locked until
// the packet's last beat. Each port is buffered by its own 2-entry register FIFO.

// Two-entry FIFO whose head entry drives the outbound stream directly from flops.
module nx_distributor_fifo #(
  parameter int BUS_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [BUS_W-1:0] in_data,
  input  logic             in_last,
  output logic [BUS_W-1:0] out_data,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             full
);

  logic [BUS_W-1:0] spare_data;
  logic             spare_last;
  logic             spare_valid;
  logic             pop;

  // Pop handshake, and the full flag that back-pressures the inbound side.
  always_comb begin
    pop  = out_valid & out_ready;
    full = spare_valid;
  end

  // Head/spare entry update. Full plus push never happens because the
  // inbound side is held off by full. Push and pop together keep occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data    <= {BUS_W{1'b0}};
      out_last    <= 1'b0;
      out_valid   <= 1'b0;
      spare_data  <= {BUS_W{1'b0}};
      spare_last  <= 1'b0;
      spare_valid <= 1'b0;
    end else begin
      case ({pop, push})
        2'b10: begin
          if (spare_valid) begin
            out_data    <= spare_data;
            out_last    <= spare_last;
            spare_valid <= 1'b0;
          end else begin
            out_valid   <= 1'b0;
          end
        end
        2'b01: begin
          if (!out_valid) begin
            out_data    <= in_data;
            out_last    <= in_last;
            out_valid   <= 1'b1;
          end else begin
            spare_data  <= in_data;
            spare_last  <= in_last;
            spare_valid <= 1'b1;
          end
        end
        2'b11: begin
          if (spare_valid) begin
            out_data    <= spare_data;
            out_last    <= spare_last;
            spare_data  <= in_data;
            spare_last  <= in_last;
          end else begin
            out_data    <= in_data;
            out_last    <= in_last;
          end
        end
        default: begin
          out_valid   <= out_valid;
          spare_valid <= spare_valid;
        end
      endcase
    end
  end

endmodule

module nx_distributor #(
  parameter int BUS_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BUS_W-1:0] inbound_data,
  input  logic             inbound_last,
  input  logic             inbound_valid,
  output logic             inbound_ready,
  output logic [BUS_W-1:0] outbound_a_data,
  output logic             outbound_a_last,
  output logic             outbound_a_valid,
  input  logic             outbound_a_ready,
  output logic [BUS_W-1:0] outbound_b_data,
  output logic             outbound_b_last,
  output logic             outbound_b_valid,
  input  logic             outbound_b_ready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROUTE_A = 2'd1,
    ROUTE_B = 2'd2
  } state_t;

  state_t state;
  logic   run;
  logic   dest_b;
  logic   accept;
  logic   push_a;
  logic   push_b;
  logic   full_a;
  logic   full_b;

  // Destination of the current beat: header MSB in IDLE, locked port otherwise.
  // Ready is held low until the first edge after reset release.
  always_comb begin
    dest_b = 1'b0;
    case (state)
      IDLE:    dest_b = inbound_data[BUS_W-1];
      ROUTE_A: dest_b = 1'b0;
      ROUTE_B: dest_b = 1'b1;
      default: dest_b = 1'b0;
    endcase
    if (dest_b) begin
      inbound_ready = run & ~full_b;
    end else begin
      inbound_ready = run & ~full_a;
    end
    accept = inbound_valid & inbound_ready;
    push_a = accept & ~dest_b;
    push_b = accept & dest_b;
  end

  // Enables inbound_ready once reset has been released for one edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run <= 1'b0;
    end else begin
      run <= 1'b1;
    end
  end

  // Packet routing FSM: opens a route on a multi-beat header and closes it on last.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept && !inbound_last) begin
            state <= dest_b ? ROUTE_B : ROUTE_A;
          end else begin
            state <= IDLE;
          end
        end
        ROUTE_A, ROUTE_B: begin
          if (accept && inbound_last) begin
            state <= IDLE;
          end else begin
            state <= state;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  nx_distributor_fifo #(.BUS_W(BUS_W)) u_fifo_a (
    .clk       (clk),
    .rst       (rst),
    .push      (push_a),
    .in_data   (inbound_data),
    .in_last   (inbound_last),
    .out_data  (outbound_a_data),
    .out_last  (outbound_a_last),
    .out_valid (outbound_a_valid),
    .out_ready (outbound_a_ready),
    .full      (full_a)
  );

  nx_distributor_fifo #(.BUS_W(BUS_W)) u_fifo_b (
    .clk       (clk),
    .rst       (rst),
    .push      (push_b),
    .in_data   (inbound_data),
    .in_last   (inbound_last),
    .out_data  (outbound_b_data),
    .out_last  (outbound_b_last),
    .out_valid (outbound_b_valid),
    .out_ready (outbound_b_ready),
    .full      (full_b)
  );

endmodule

// File: tb/tb_nx_distributor.sv
// Testbench for nx_distributor: directed vector table, reset sequence, and a
// randomized run checked against a queue-based model of the routing rules.
module tb_nx_distributor;

  localparam int BUS_W = 8;

  logic             clk;
  logic             rst;
  logic [BUS_W-1:0] in_data;
  logic             in_last;
  logic             in_valid;
  logic             in_ready;
  logic [BUS_W-1:0] a_data;
  logic             a_last;
  logic             a_valid;
  logic             a_ready;
  logic [BUS_W-1:0] b_data;
  logic             b_last;
  logic             b_valid;
  logic             b_ready;

  int n_checks = 0;
  int n_fail   = 0;

  nx_distributor #(.BUS_W(BUS_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .inbound_data     (in_data),
    .inbound_last     (in_last),
    .inbound_valid    (in_valid),
    .inbound_ready    (in_ready),
    .outbound_a_data  (a_data),
    .outbound_a_last  (a_last),
    .outbound_a_valid (a_valid),
    .outbound_a_ready (a_ready),
    .outbound_b_data  (b_data),
    .outbound_b_last  (b_last),
    .outbound_b_valid (b_valid),
    .outbound_b_ready (b_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One table row = one cycle: inputs, then outputs expected just before the edge.
  typedef struct packed {
    logic [7:0] d;
    logic       l, v, ar, br;
    logic       er;
    logic       eav;
    logic [7:0] ead;
    logic       eal;
    logic       ebv;
    logic [7:0] ebd;
    logic       ebl;
  } vec_t;

  vec_t vecs [18];

  // Reference model state for the random run.
  logic [8:0] qa[$];
  logic [8:0] qb[$];
  logic       pkt_open;
  logic       pkt_dest;
  logic       dest;
  logic       exp_rdy;
  logic       have_beat;
  int         rem;
  logic       a_stall, b_stall;
  logic [8:0] a_hold, b_hold;

  initial begin
    //           d     l    v    ar   br   er   eav  ead    eal  ebv  ebd    ebl
    vecs[0]  = '{8'h05,1'b0,1'b1,1'b1,1'b1,1'b1,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0};
    vecs[1]  = '{8'hAA,1'b0,1'b1,1'b1,1'b1,1'b1,1'b1,8'h05,1'b0,1'b0,8'h00,1'b0};
    vecs[2]  = '{8'h11,1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,8'hAA,1'b0,1'b0,8'h00,1'b0};
    vecs[3]  = '{8'h00,1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,8'h11,1'b1,1'b0,8'h00,1'b0};
    vecs[4]  = '{8'h85,1'b0,1'b1,1'b1,1'b1,1'b1,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0};
    vecs[5]  = '{8'h05,1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,8'h00,1'b0,1'b1,8'h85,1'b0};
    vecs[6]  = '{8'h00,1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,8'h00,1'b0,1'b1,8'h05,1'b1};
    vecs[7]  = '{8'h01,1'b1,1'b1,1'b0,1'b1,1'b1,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0};
    vecs[8]  = '{8'h02,1'b1,1'b1,1'b0,1'b1,1'b1,1'b1,8'h01,1'b1,1'b0,8'h00,1'b0};
    vecs[9]  = '{8'h03,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,8'h01,1'b1,1'b0,8'h00,1'b0};
    vecs[10] = '{8'h80,1'b1,1'b1,1'b0,1'b1,1'b1,1'b1,8'h01,1'b1,1'b0,8'h00,1'b0};
    vecs[11] = '{8'h00,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,8'h01,1'b1,1'b1,8'h80,1'b1};
    vecs[12] = '{8'h00,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,8'h01,1'b1,1'b0,8'h00,1'b0};
    vecs[13] = '{8'h00,1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,8'h02,1'b1,1'b0,8'h00,1'b0};
    vecs[14] = '{8'h7F,1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0};
    vecs[15] = '{8'h81,1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,8'h7F,1'b1,1'b0,8'h00,1'b0};
    vecs[16] = '{8'h00,1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,8'h00,1'b0,1'b1,8'h81,1'b1};
    vecs[17] = '{8'h00,1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0};

    rst      = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
    in_valid = 1'b0;
    a_ready  = 1'b0;
    b_ready  = 1'b0;

    // Reset state, with a B header offered so ready would otherwise be high.
    repeat (3) @(negedge clk);
    in_data  = 8'h80;
    in_valid = 1'b1;
    #4;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_a_valid", a_valid, 1'b0);
    check("rst_b_valid", b_valid, 1'b0);
    check("rst_a_data", a_data, 8'h00);
    check("rst_b_data", b_data, 8'h00);
    check("rst_a_last", a_last, 1'b0);
    check("rst_b_last", b_last, 1'b0);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);

    // Directed vector table.
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      in_data  = vecs[i].d;
      in_last  = vecs[i].l;
      in_valid = vecs[i].v;
      a_ready  = vecs[i].ar;
      b_ready  = vecs[i].br;
      #4;
      check($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].er);
      check($sformatf("vec%0d_a_valid", i), a_valid, vecs[i].eav);
      check($sformatf("vec%0d_b_valid", i), b_valid, vecs[i].ebv);
      if (vecs[i].eav) begin
        check($sformatf("vec%0d_a_beat", i), {a_last, a_data}, {vecs[i].eal, vecs[i].ead});
      end
      if (vecs[i].ebv) begin
        check($sformatf("vec%0d_b_beat", i), {b_last, b_data}, {vecs[i].ebl, vecs[i].ebd});
      end
    end

    // Reset in the middle of a packet whose header 0x01 is buffered on A.
    @(negedge clk);
    in_data  = 8'h01;
    in_last  = 1'b0;
    in_valid = 1'b1;
    a_ready  = 1'b0;
    b_ready  = 1'b1;
    #4;
    check("mid_hdr_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #4;
    check("mid_hdr_buffered", a_valid, 1'b1);
    rst = 1'b0;
    #1;
    check("mid_rst_a_valid", a_valid, 1'b0);
    check("mid_rst_b_valid", b_valid, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_data  = 8'h9F;
    in_last  = 1'b1;
    in_valid = 1'b1;
    #4;
    check("post_rst_ready", in_ready, 1'b1);
    check("post_rst_a_valid", a_valid, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #4;
    check("post_rst_b_valid", b_valid, 1'b1);
    check("post_rst_b_beat", {b_last, b_data}, {1'b1, 8'h9F});
    check("post_rst_a_idle", a_valid, 1'b0);

    // Clean start for the random run.
    @(negedge clk);
    rst     = 1'b0;
    a_ready = 1'b0;
    b_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);

    qa.delete();
    qb.delete();
    pkt_open  = 1'b0;
    pkt_dest  = 1'b0;
    have_beat = 1'b0;
    rem       = 0;
    a_stall   = 1'b0;
    b_stall   = 1'b0;
    a_hold    = 9'h000;
    b_hold    = 9'h000;

    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      if (!have_beat) begin
        if (rem == 0) begin
          rem     = int'($urandom_range(1, 4));
          in_data = {1'($urandom_range(0, 1)), 7'($urandom)};
        end else begin
          in_data = 8'($urandom);
        end
        in_last   = (rem == 1);
        rem       = rem - 1;
        have_beat = 1'b1;
      end
      in_valid = ($urandom_range(0, 3) != 0);
      a_ready  = ($urandom_range(0, 2) != 0);
      b_ready  = ($urandom_range(0, 2) != 0);
      #4;

      dest    = pkt_open ? pkt_dest : in_data[BUS_W-1];
      exp_rdy = dest ? (qb.size() < 2) : (qa.size() < 2);
      check("rand_in_ready", in_ready, exp_rdy);
      check("rand_a_valid", a_valid, qa.size() != 0);
      check("rand_b_valid", b_valid, qb.size() != 0);
      if (qa.size() != 0) check("rand_a_beat", {a_last, a_data}, qa[0]);
      if (qb.size() != 0) check("rand_b_beat", {b_last, b_data}, qb[0]);
      if (a_stall) check("rand_a_stall_hold", {a_valid, a_last, a_data}, {1'b1, a_hold});
      if (b_stall) check("rand_b_stall_hold", {b_valid, b_last, b_data}, {1'b1, b_hold});

      // Model update for the coming edge: pops first, then the push.
      if (a_valid && a_ready && qa.size() != 0) void'(qa.pop_front());
      if (b_valid && b_ready && qb.size() != 0) void'(qb.pop_front());
      a_stall = a_valid && !a_ready;
      b_stall = b_valid && !b_ready;
      a_hold  = {a_last, a_data};
      b_hold  = {b_last, b_data};
      if (in_valid && in_ready) begin
        if (dest) qb.push_back({in_last, in_data});
        else      qa.push_back({in_last, in_data});
        if (!pkt_open && !in_last) begin
          pkt_open = 1'b1;
          pkt_dest = dest;
        end else if (pkt_open && in_last) begin
          pkt_open = 1'b0;
        end
        have_beat = 1'b0;
      end
    end

    @(negedge clk);
    in_valid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nx_distributor.md
NX_DISTRIBUTOR -- requirements
Module: nx_distributor

Interface
REQ-001 SHALL have parameter BUS_W, default 8: width of every data bus in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 SHALL have port: inbound_data  input  BUS_W  inbound stream data.
REQ-005 SHALL have port: inbound_last  input  1  marks final beat of a packet.
REQ-006 SHALL have port: inbound_valid  input  1  inbound beat present.
REQ-007 SHALL have port: inbound_ready  output  1  inbound beat accepted when high with valid.
REQ-008 SHALL have ports outbound_a_data (output, BUS_W), outbound_a_last (output, 1), outbound_a_valid (output, 1), outbound_a_ready (input, 1): port A stream.
REQ-009 SHALL have ports outbound_b_data (output, BUS_W), outbound_b_last (output, 1), outbound_b_valid (output, 1), outbound_b_ready (input, 1): port B stream.

Function
REQ-010 SHALL transfer a beat on any interface only in a cycle where valid and ready are both high at the rising edge of clk.
REQ-011 SHALL define a packet as consecutive accepted inbound beats ending with, and including, the beat where inbound_last=1; a single-beat packet (header with last=1) SHALL be legal.
REQ-012 SHALL implement states IDLE (no packet open), ROUTE_A and ROUTE_B (packet open to port A or B).
REQ-013 In IDLE, the destination SHALL be inbound_data[BUS_W-1] of the header beat: 0 selects A, 1 selects B.
REQ-014 Header acceptance with last=0 SHALL move IDLE to ROUTE_A or ROUTE_B; with last=1, the state SHALL stay IDLE.
REQ-015 In ROUTE_A or ROUTE_B, every accepted beat SHALL go to the locked port, regardless of its data MSB.
REQ-016 Acceptance of a beat with last=1 in a ROUTE state SHALL return the state to IDLE on the same edge.
REQ-017 All beats, including the header, SHALL be forwarded unmodified (full BUS_W data plus last).
REQ-018 Each outbound port SHALL own a 2-entry FIFO, driving its outbound_*_data, _last and _valid directly from registers.
REQ-019 inbound_ready SHALL be high iff the FIFO of the current destination has at least one free entry; in IDLE the destination is given by inbound_data[BUS_W-1], so inbound_ready combinationally depends on that bit.
REQ-020 Latency SHALL be exactly 1 cycle: a beat accepted at edge N SHALL present valid on its outbound port after edge N when that FIFO was empty.
REQ-021 With the destination outbound ready held high, throughput SHALL be one beat per cycle with no bubbles.
REQ-022 Simultaneous push and pop on a full FIFO SHALL NOT occur (ready low); on a 1-entry FIFO, simultaneous push and pop SHALL keep occupancy at 1.
REQ-023 Beat order SHALL be preserved per port; ports A and B SHALL drain independently, so a stalled port SHALL NOT stall traffic destined for the other port.
REQ-024 outbound_*_valid SHALL never drop, nor its data/last change, while valid is high and ready is low.
REQ-025 inbound_valid low SHALL change no state.

Reset
REQ-026 While rst=0, state SHALL be IDLE, both FIFOs empty, outbound_a_valid=outbound_b_valid=0, outbound_*_data=0, outbound_*_last=0, and inbound_ready=0.
REQ-027 Reset asserted mid-packet SHALL discard the open packet and all buffered beats; after release the first accepted beat SHALL be treated as a header.
REQ-028 inbound_ready SHALL be allowed high from the first rising edge after rst deasserts.

Verification
REQ-029 Bench SHALL cover: BUS_W=8, both readys=1, packet 0x05,0xAA,0x11(last) -> port A emits 0x05,0xAA,0x11 on consecutive cycles, last only on 0x11; port B idle.
REQ-030 Bench SHALL cover: header 0x85 then 0x05(last) -> both beats on port B, 0x05 not re-routed to A.
REQ-031 Bench SHALL cover: outbound_a_ready=0, two A beats pushed -> inbound_ready low for A header; a B header 0x80(last) is accepted and emitted on B.
REQ-032 Bench SHALL cover: single-beat packet 0x7F(last=1) followed by 0x81(last=1) -> 0x7F on A, 0x81 on B, state IDLE after each.
REQ-033 Bench SHALL cover: reset pulsed after header 0x01 is accepted -> both outbound valids 0; next beat 0x9F(last) emitted on B.
REQ-034 Bench SHALL cover: random packets (MSB 0/1), random outbound readys for 10000 cycles -> each port's received stream equals the sent per-destination stream; no valid/data change while stalled.
